// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, 32 iterations per op, one rd write per op.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [2:0] op;
    logic sa, sb, dz, accept, is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] hi, lo, m, hi_n, lo_n, q, r, res, mag_a, mag_b;
    logic [XLEN:0] sum, rsh, diff;
    logic [2*XLEN-1:0] prod;

    always_ff @(posedge i_clk)
        state <= !i_rst ? IDLE : state_n;

    always_comb begin
        accept  = state == IDLE && i_valid && !i_flush;
        state_n = i_flush ? IDLE :
                  state == IDLE ? (i_valid ? CALC : IDLE) :
                  state == CALC ? (&cnt ? DONE : CALC) : IDLE;
    end

    // Operand magnitudes and sign flags, captured only on accept
    always_comb begin
        is_div = i_funct3[2];
        sgn_a  = is_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10);
        sgn_b  = is_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
        neg_a  = sgn_a & i_rs1_data[XLEN-1];
        neg_b  = sgn_b & i_rs2_data[XLEN-1];
        mag_a  = neg_a ? -i_rs1_data : i_rs1_data;
        mag_b  = neg_b ? -i_rs2_data : i_rs2_data;
    end

    // Multiply: {hi,lo} is the shift-add product with the multiplier in lo.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, lo[0] ? m : '0};
        rsh  = {hi, lo[XLEN-1]};
        diff = rsh - {1'b0, m};
        hi_n = op[2] ? (diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
        lo_n = op[2] ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
        prod = (sa ^ sb) ? -{hi_n, lo_n} : {hi_n, lo_n};
        q    = dz ? '1 : (sa ^ sb) ? -lo_n : lo_n;
        r    = sa ? -hi_n : hi_n;
        res  = op[2] ? (op[1] ? r : q) :
               (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt       <= '0;
            op        <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            dz        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            m         <= '0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (accept) begin
            cnt       <= '0;
            op        <= i_funct3;
            sa        <= neg_a;
            sb        <= neg_b;
            dz        <= i_rs2_data == '0;
            hi        <= '0;
            lo        <= is_div ? mag_a : mag_b;
            m         <= is_div ? mag_b : mag_a;
            o_rd_addr <= i_rd_addr;
        end else if (state == CALC && !i_flush) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            if (&cnt)
                o_rd_data <= res;
        end
    end

    always_comb begin
        o_ready   = state == IDLE;
        o_busy    = state != IDLE;
        o_done    = state == DONE;
        o_rd_wren = o_done && o_rd_addr != '0;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random + directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 0, rst = 0, valid = 0, flush = 0;
    logic [2:0] f3 = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0] rd = '0;
    logic ready, busy, done, wren;
    logic [4:0] oaddr;
    logic [31:0] odata;
    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    muldiv_unit dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_funct3(f3),
        .i_rs1_data(a), .i_rs2_data(b), .i_rd_addr(rd), .i_flush(flush),
        .o_ready(ready), .o_busy(busy), .o_done(done), .o_rd_addr(oaddr),
        .o_rd_data(odata), .o_rd_wren(wren)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RV32M results straight from two's-complement arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        logic ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return y == 0 ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            3'd5: return y == 0 ? 32'hFFFF_FFFF : x / y;
            3'd6: return y == 0 ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return y == 0 ? x : x % y;
        endcase
    endfunction

    // Timing model: idle until accepted, done 32 edges later, idle the edge after
    logic m_ready, m_done;
    logic [4:0] m_addr;
    logic [31:0] m_data, m_exp;
    int remain;

    always @(posedge clk) begin
        if (!rst) begin
            m_ready <= 1; m_done <= 0; remain <= 0; m_addr <= 0; m_data <= 0;
        end else if (flush) begin
            m_ready <= 1; m_done <= 0; remain <= 0;
        end else if (m_ready && valid) begin
            m_ready <= 0; remain <= 32; m_addr <= rd; m_exp <= ref_res(f3, a, b);
        end else if (remain > 0) begin
            remain <= remain - 1;
            if (remain == 1) begin
                m_done <= 1;
                m_data <= m_exp;
            end
        end else if (m_done) begin
            m_done <= 0; m_ready <= 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, m_ready);
            chk("busy", busy, !m_ready);
            chk("done", done, m_done);
            chk("wren", wren, m_done && m_addr != 0);
            chk("rd_addr", oaddr, m_addr);
            if (m_done) chk("rd_data", odata, m_data);
        end
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r);
        @(negedge clk);
        valid = 1; f3 = f; a = x; b = y; rd = r;
        for (int g = 0; g < 200 && !m_ready; g++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        valid = 0; a = $urandom; b = $urandom; rd = 5'($urandom);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                         output int lat, output logic [31:0] got, output logic got_wren);
        start_op(f, x, y, r);
        lat = 0; got = '0; got_wren = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; got = odata; got_wren = wren; break; end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  d_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_e [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};

    initial begin
        int lat, pulses;
        logic [31:0] got, x, y;
        logic gw;
        logic [2:0] f;
        logic [4:0] r;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_wren", wren, 0); chk("rst_addr", oaddr, 0); chk("rst_data", odata, 0);
        chk_en = 1;
        @(negedge clk); rst = 1;

        for (int i = 0; i < 12; i++) begin
            chk("model_pin", ref_res(d_f[i], d_a[i], d_b[i]), d_e[i]);
            do_op(d_f[i], d_a[i], d_b[i], 5'(i + 1), lat, got, gw);
            chk("latency", lat, 32);
            chk("result", got, d_e[i]);
            chk("result_wren", gw, 1);
        end

        do_op(3'd0, 32'd3, 32'd4, 5'd0, lat, got, gw);
        chk("rd0_lat", lat, 32); chk("rd0_data", got, 12); chk("rd0_wren", gw, 0);

        start_op(3'd0, 32'd9, 32'd9, 5'd3);
        repeat (9) @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        chk("flush_ready", ready, 1); chk("flush_done", done, 0);
        @(negedge clk); flush = 0;
        repeat (40) @(negedge clk);

        @(negedge clk); valid = 1; flush = 1; f3 = 3'd0; a = 32'd2; b = 32'd2; rd = 5'd4;
        @(posedge clk); #1;
        chk("vf_ready", ready, 1); chk("vf_busy", busy, 0);
        @(negedge clk); valid = 0; flush = 0;

        start_op(3'd5, 32'd1000, 32'd3, 5'd9);
        repeat (5) @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("mid_rst_ready", ready, 1); chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", oaddr, 0);
        chk("mid_rst_data", odata, 0); chk("mid_rst_wren", wren, 0);
        @(negedge clk); rst = 1;
        repeat (40) @(negedge clk);

        @(negedge clk); valid = 1; f3 = 3'd0; a = 32'd5; b = 32'd6; rd = 5'd7;
        for (int g = 0; g < 200 && !m_ready; g++) @(negedge clk);
        @(posedge clk);
        pulses = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; got = odata; end
            if (k == 50) valid = 0;
        end
        chk("held_pulses", 64'(pulses), 2);
        chk("held_data", got, 30);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7)); x = pick(); y = pick(); r = 5'($urandom);
            do_op(f, x, y, r, lat, got, gw);
            chk("rand_lat", lat, 32);
            chk("rand_data", got, ref_res(f, x, y));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
